// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame loader.
// The loader and its sign-magnitude converter both import this package.
package fft_pkg;

    localparam int unsigned N_POINTS = 8;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SLOT_W   = 3;

    localparam logic [SAMPLE_W-1:0] SM_NEG_FULL = 16'hFFFF;
    localparam logic [SAMPLE_W-1:0] TC_NEG_MAX  = 16'h8000;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SLOT_W-1:0]   slot_idx_t;

    typedef enum logic [1:0] {
        FILL,
        LOAD,
        START,
        DONE
    } loader_state_e;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Valid/ready sample stream carrying one two's-complement complex sample per beat.
// The source drives data and valid; the loader returns ready.
interface fft_frame_loader_if;
    import fft_pkg::*;

    logic    s_valid;
    logic    s_ready;
    sample_t s_real;
    sample_t s_imag;
    logic    s_last;

    modport master (
        output s_valid,
        output s_real,
        output s_imag,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_real,
        input  s_imag,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/fft_frame_loader_tc_to_signmag.sv
// Combinational two's-complement to sign-magnitude converter for one component.
// The most negative code has no sign-magnitude image, so it clips to -32767.
module tc_to_signmag
    import fft_pkg::*;
(
    input  sample_t tc_i,
    output sample_t sm_o,
    output logic    sat_o
);

    sample_t mag;

    assign mag = sample_t'(~tc_i + sample_t'(1));

    always_comb begin
        sm_o  = tc_i;
        sat_o = 1'b0;
        if (tc_i[SAMPLE_W-1]) begin
            if (tc_i == TC_NEG_MAX) begin
                sm_o  = SM_NEG_FULL;
                sat_o = 1'b1;
            end else begin
                sm_o = {1'b1, mag[SAMPLE_W-2:0]};
            end
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Collects 8 converted samples into a parallel frame, then pulses fft_write,
// holds fft_start for START_CYCLES cycles and flags frame_done.
module fft_frame_loader #(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned N_POINTS     = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    fft_frame_loader_if.slave         s_bus,
    output logic [fft_pkg::SAMPLE_W-1:0] x0_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x0_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x1_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x1_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x2_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x2_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x3_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x3_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x4_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x4_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x5_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x5_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x6_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x6_imag,
    output logic [fft_pkg::SAMPLE_W-1:0] x7_real,
    output logic [fft_pkg::SAMPLE_W-1:0] x7_imag,
    output logic                      fft_write,
    output logic                      fft_start,
    output logic                      frame_done,
    output logic                      sat_flag
);

    if (N_POINTS != fft_pkg::N_POINTS) begin : g_bad_points
        $error("fft_frame_loader: N_POINTS must be 8");
    end
    // The FFT output registers trail the butterflies by one start cycle.
    if (START_CYCLES < 2) begin : g_bad_start
        $error("fft_frame_loader: START_CYCLES must be at least 2");
    end

    localparam int unsigned SCW = $clog2(START_CYCLES);
    localparam fft_pkg::slot_idx_t LAST_SLOT = fft_pkg::slot_idx_t'(N_POINTS - 1);

    fft_pkg::loader_state_e state_q, state_d;
    fft_pkg::slot_idx_t     cnt_q, cnt_d;
    logic [SCW-1:0]         start_cnt_q, start_cnt_d;
    logic                   sat_q, sat_d;
    fft_pkg::sample_t       slot_re_q [N_POINTS];
    fft_pkg::sample_t       slot_re_d [N_POINTS];
    fft_pkg::sample_t       slot_im_q [N_POINTS];
    fft_pkg::sample_t       slot_im_d [N_POINTS];

    fft_pkg::sample_t sm_re, sm_im;
    logic             sat_re, sat_im;
    logic             ready;
    logic             accept;

    tc_to_signmag u_conv_re (
        .tc_i  (s_bus.s_real),
        .sm_o  (sm_re),
        .sat_o (sat_re)
    );

    tc_to_signmag u_conv_im (
        .tc_i  (s_bus.s_imag),
        .sm_o  (sm_im),
        .sat_o (sat_im)
    );

    assign ready       = (state_q == fft_pkg::FILL) && !RST;
    assign accept      = s_bus.s_valid && ready;
    assign s_bus.s_ready = ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_cnt_d = start_cnt_q;
        sat_d       = sat_q;
        slot_re_d   = slot_re_q;
        slot_im_d   = slot_im_q;
        fft_write   = 1'b0;
        fft_start   = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            fft_pkg::FILL: begin
                if (accept) begin
                    // A short frame zero-pads every slot above the last sample.
                    for (int i = 0; i < N_POINTS; i++) begin
                        if (fft_pkg::slot_idx_t'(i) == cnt_q) begin
                            slot_re_d[i] = sm_re;
                            slot_im_d[i] = sm_im;
                        end else if (s_bus.s_last && (fft_pkg::slot_idx_t'(i) > cnt_q)) begin
                            slot_re_d[i] = '0;
                            slot_im_d[i] = '0;
                        end
                    end
                    sat_d = sat_q | sat_re | sat_im;
                    cnt_d = cnt_q + fft_pkg::slot_idx_t'(1);
                    if ((cnt_q == LAST_SLOT) || s_bus.s_last) begin
                        state_d = fft_pkg::LOAD;
                    end
                end
            end
            fft_pkg::LOAD: begin
                fft_write   = 1'b1;
                start_cnt_d = SCW'(START_CYCLES - 1);
                state_d     = fft_pkg::START;
            end
            fft_pkg::START: begin
                fft_start = 1'b1;
                if (start_cnt_q == '0) begin
                    state_d = fft_pkg::DONE;
                end else begin
                    start_cnt_d = start_cnt_q - SCW'(1);
                end
            end
            fft_pkg::DONE: begin
                frame_done = 1'b1;
                cnt_d      = '0;
                state_d    = fft_pkg::FILL;
            end
            default: begin
                state_d = fft_pkg::FILL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= fft_pkg::FILL;
            cnt_q       <= '0;
            start_cnt_q <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < N_POINTS; i++) begin
                slot_re_q[i] <= '0;
                slot_im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_cnt_q <= start_cnt_d;
            sat_q       <= sat_d;
            for (int i = 0; i < N_POINTS; i++) begin
                slot_re_q[i] <= slot_re_d[i];
                slot_im_q[i] <= slot_im_d[i];
            end
        end
    end

    assign sat_flag = sat_q;

    assign x0_real = slot_re_q[0];
    assign x1_real = slot_re_q[1];
    assign x2_real = slot_re_q[2];
    assign x3_real = slot_re_q[3];
    assign x4_real = slot_re_q[4];
    assign x5_real = slot_re_q[5];
    assign x6_real = slot_re_q[6];
    assign x7_real = slot_re_q[7];
    assign x0_imag = slot_im_q[0];
    assign x1_imag = slot_im_q[1];
    assign x2_imag = slot_im_q[2];
    assign x3_imag = slot_im_q[3];
    assign x4_imag = slot_im_q[4];
    assign x5_imag = slot_im_q[5];
    assign x6_imag = slot_im_q[6];
    assign x7_imag = slot_im_q[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: randomized and directed sample streams feed a reference
// model whose expected frames and control timing are checked by an independent monitor.
module tb_fft_frame_loader;

    localparam int unsigned SC = 2;
    localparam int NO_SAT = 32'h7fffffff;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [7:0][15:0] xr, xi;
    logic fft_write, fft_start, frame_done, sat_flag;

    fft_frame_loader_if bus ();

    fft_frame_loader #(
        .START_CYCLES (SC),
        .N_POINTS     (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .s_bus      (bus),
        .x0_real    (xr[0]),
        .x0_imag    (xi[0]),
        .x1_real    (xr[1]),
        .x1_imag    (xi[1]),
        .x2_real    (xr[2]),
        .x2_imag    (xi[2]),
        .x3_real    (xr[3]),
        .x3_imag    (xi[3]),
        .x4_real    (xr[4]),
        .x4_imag    (xi[4]),
        .x5_real    (xr[5]),
        .x5_imag    (xi[5]),
        .x6_real    (xr[6]),
        .x6_imag    (xi[6]),
        .x7_real    (xr[7]),
        .x7_imag    (xi[7]),
        .fft_write  (fft_write),
        .fft_start  (fft_start),
        .frame_done (frame_done),
        .sat_flag   (sat_flag)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int               wcyc;
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
    } frame_t;

    // Reference model state, owned by the stimulus process.
    frame_t      exp_q[$];
    logic [15:0] fill_re[$];
    logic [15:0] fill_im[$];
    int          sat_cyc = NO_SAT;
    int          busy_lo = -1;
    int          busy_hi = -1;
    int          tmo_cnt = 0;
    bit          end_req = 1'b0;

    // Scoreboard counters, owned by the monitor process.
    int total = 0;
    int bad = 0;

    function automatic void conv(input logic [15:0] v, output logic [15:0] sm, output bit sat);
        int sv;
        sv  = int'($signed(v));
        sat = 1'b0;
        if (sv == -32768) begin
            sm  = 16'hFFFF;
            sat = 1'b1;
        end else if (sv < 0) begin
            sm = 16'h8000 | 16'(-sv);
        end else begin
            sm = v;
        end
    endfunction

    function automatic void model_accept(input logic [15:0] r, input logic [15:0] i,
                                         input bit l, input int k);
        logic [15:0] sr, si;
        bit          s1, s2;
        frame_t      f;
        conv(r, sr, s1);
        conv(i, si, s2);
        fill_re.push_back(sr);
        fill_im.push_back(si);
        if ((s1 || s2) && sat_cyc == NO_SAT) sat_cyc = k;
        if (fill_re.size() == 8 || l) begin
            f.re = '0;
            f.im = '0;
            for (int n = 0; n < fill_re.size(); n++) begin
                f.re[n] = fill_re[n];
                f.im[n] = fill_im[n];
            end
            f.wcyc  = k + 1;
            exp_q.push_back(f);
            busy_lo = k + 1;
            busy_hi = k + 2 + SC;
            fill_re.delete();
            fill_im.delete();
        end
    endfunction

    function automatic logic [15:0] rnd_sample();
        if ($urandom_range(0, 15) == 0) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic push_sample(input logic [15:0] r, input logic [15:0] i, input bit l,
                               input int gaps);
        repeat (gaps) begin
            @(posedge CLK);
            #1;
            bus.s_valid = 1'b0;
        end
        for (int n = 0; n < 64; n++) begin
            @(posedge CLK);
            #1;
            bus.s_valid = 1'b1;
            bus.s_real  = r;
            bus.s_imag  = i;
            bus.s_last  = l;
            #1;
            if (bus.s_ready) begin
                model_accept(r, i, l, cyc);
                return;
            end
        end
        tmo_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        exp_q.delete();
        fill_re.delete();
        fill_im.delete();
        sat_cyc = NO_SAT;
        busy_lo = -1;
        busy_hi = -1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: compares DUT outputs with the model at every falling edge.
    int     pending = -1;
    frame_t last_f;
    always @(negedge CLK) begin
        if (end_req) begin
            check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
            check("accept_timeouts", 32'(tmo_cnt), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (RST) begin
            pending = -1;
        end else begin
            check("s_ready", {31'd0, bus.s_ready},
                  {31'd0, !(cyc >= busy_lo && cyc <= busy_hi)});
            check("sat_flag", {31'd0, sat_flag}, {31'd0, cyc > sat_cyc});
            if (pending >= 0) begin
                check("fft_start", {31'd0, fft_start},
                      {31'd0, cyc >= pending + 1 && cyc <= pending + int'(SC)});
                check("frame_done", {31'd0, frame_done}, {31'd0, cyc == pending + int'(SC) + 1});
                if (cyc == pending + int'(SC) + 1) begin
                    for (int n = 0; n < 8; n++) begin
                        check($sformatf("hold_re%0d", n), {16'd0, xr[n]}, {16'd0, last_f.re[n]});
                        check($sformatf("hold_im%0d", n), {16'd0, xi[n]}, {16'd0, last_f.im[n]});
                    end
                    pending = -1;
                end
            end else begin
                check("idle_start_done", {30'd0, fft_start, frame_done}, 32'd0);
            end
            if (fft_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    last_f = exp_q.pop_front();
                    check("write_cycle", 32'(cyc), 32'(last_f.wcyc));
                    for (int n = 0; n < 8; n++) begin
                        check($sformatf("x%0d_real", n), {16'd0, xr[n]}, {16'd0, last_f.re[n]});
                        check($sformatf("x%0d_imag", n), {16'd0, xi[n]}, {16'd0, last_f.im[n]});
                    end
                    pending = cyc;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].wcyc) begin
                check("missing_write", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit l;
        bus.s_valid = 1'b0;
        bus.s_real  = '0;
        bus.s_imag  = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(2);

        // Ramp frame, back to back.
        for (int k = 0; k < 8; k++) push_sample(16'(k), 16'd0, 1'b0, 0);
        idle(6);

        // Negative and saturating values.
        push_sample(16'hFFFB, 16'h8000, 1'b0, 0);
        for (int k = 1; k < 8; k++) push_sample(rnd_sample(), rnd_sample(), 1'b0, 0);
        idle(6);

        // Short frame ending on the third sample.
        push_sample(16'd1, 16'd0, 1'b0, 0);
        push_sample(16'd2, 16'd0, 1'b0, 0);
        push_sample(16'd3, 16'd0, 1'b1, 0);
        idle(6);

        // Valid toggling during fill, held high through load/start across two frames.
        for (int k = 0; k < 16; k++) push_sample(16'(100 + k), 16'(200 + k), 1'b0, 1);
        idle(6);

        // Abort mid-frame, then a fresh frame.
        for (int k = 0; k < 5; k++) push_sample(16'(50 + k), 16'hFFFF, 1'b0, 0);
        idle(1);
        do_reset();
        for (int k = 0; k < 8; k++) push_sample(16'(300 + k), 16'(400 + k), 1'b0, 0);
        idle(6);

        // Random frames with random length, gaps and values.
        for (int f = 0; f < 25; f++) begin
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 8;
            for (int k = 0; k < n; k++) begin
                l = (k == n - 1) && ((n < 8) || ($urandom_range(0, 1) == 1));
                push_sample(rnd_sample(), rnd_sample(), l, int'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
        end
        idle(1);
        do_reset();
        idle(3);
        for (int k = 0; k < 8; k++) push_sample(16'(k * 1000), 16'(-k), 1'b0, 0);
        idle(10);
        end_req = 1'b1;
    end

endmodule
